// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for cache_ctrl.
// The master modport is the CPU/memory environment; slave is the cache controller.
interface cache_ctrl_if #(
    parameter int MEM_ADDR_SIZE   = 19,
    parameter int CACHE_LINE_SIZE = 16
);
    logic                         cpu_req;
    logic                         cpu_we;
    logic [MEM_ADDR_SIZE-1:0]     cpu_addr;
    logic [7:0]                   cpu_wdata;
    logic [7:0]                   cpu_rdata;
    logic                         cpu_done;
    logic                         cpu_busy;
    logic [1:0]                   mem_cmd;
    logic [MEM_ADDR_SIZE-1:0]     mem_addr;
    logic [8*CACHE_LINE_SIZE-1:0] mem_wdata;
    logic [8*CACHE_LINE_SIZE-1:0] mem_rdata;
    logic                         mem_resp;
    logic [15:0]                  hit_count;
    logic [15:0]                  miss_count;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_resp,
        input  cpu_rdata, cpu_done, cpu_busy, mem_cmd, mem_addr, mem_wdata,
               hit_count, miss_count
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata, mem_resp,
        output cpu_rdata, cpu_done, cpu_busy, mem_cmd, mem_addr, mem_wdata,
               hit_count, miss_count
    );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a line-wide memory.
// One CPU access at a time; at most one memory command outstanding.
module cache_ctrl #(
    parameter int MEM_ADDR_SIZE     = 19,
    parameter int CACHE_LINE_SIZE   = 16,
    parameter int CACHE_OFFSET_SIZE = 4,
    parameter int CACHE_SETS        = 32,
    parameter int CACHE_INDEX_SIZE  = 5
) (
    input logic         clk,
    input logic         reset_n,
    cache_ctrl_if.slave bus
);
    localparam int TAG_SIZE = MEM_ADDR_SIZE - CACHE_INDEX_SIZE - CACHE_OFFSET_SIZE;
    localparam int LINE_W   = 8 * CACHE_LINE_SIZE;

    localparam logic [1:0] CMD_NONE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd2;
    localparam logic [1:0] CMD_WRITE = 2'd3;

    typedef enum logic [2:0] {IDLE, LOOKUP, WRITEBACK, FILL, RESP} state_t;

    state_t                   state;
    logic                     we_q;
    logic [MEM_ADDR_SIZE-1:0] addr_q;
    logic [7:0]               wdata_q;
    logic [CACHE_SETS-1:0]    valid;
    logic [CACHE_SETS-1:0]    dirty;

    logic [LINE_W-1:0]   data_arr [CACHE_SETS];
    logic [TAG_SIZE-1:0] tag_arr  [CACHE_SETS];

    logic [TAG_SIZE-1:0]          tag_q;
    logic [CACHE_INDEX_SIZE-1:0]  idx_q;
    logic [CACHE_OFFSET_SIZE-1:0] off_q;
    logic                         hit;
    logic                         fill_done;
    logic                         arr_we;
    logic [LINE_W-1:0]            upd_line;
    logic [7:0]                   rd_byte;

    assign tag_q = addr_q[MEM_ADDR_SIZE-1 -: TAG_SIZE];
    assign idx_q = addr_q[CACHE_OFFSET_SIZE +: CACHE_INDEX_SIZE];
    assign off_q = addr_q[CACHE_OFFSET_SIZE-1:0];

    assign hit       = valid[idx_q] && (tag_arr[idx_q] == tag_q);
    // Memory responses only count while our own read command is actually on the bus
    assign fill_done = (state == FILL) && (bus.mem_cmd == CMD_READ) && bus.mem_resp;
    assign arr_we    = ((state == LOOKUP) && hit && we_q) || fill_done;

    // Line as it will be after this access: resident or freshly filled, with the CPU byte merged on writes
    always_comb begin
        upd_line = (state == FILL) ? bus.mem_rdata : data_arr[idx_q];
        if (we_q)
            upd_line[8*off_q +: 8] = wdata_q;
        rd_byte = upd_line[8*off_q +: 8];
    end

    always_ff @(posedge clk) begin
        if (arr_we) begin
            data_arr[idx_q] <= upd_line;
            tag_arr[idx_q]  <= tag_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            we_q           <= 1'b0;
            addr_q         <= '0;
            wdata_q        <= '0;
            valid          <= '0;
            dirty          <= '0;
            bus.cpu_rdata  <= '0;
            bus.cpu_done   <= 1'b0;
            bus.cpu_busy   <= 1'b0;
            bus.mem_cmd    <= CMD_NONE;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.hit_count  <= '0;
            bus.miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req) begin
                        we_q         <= bus.cpu_we;
                        addr_q       <= bus.cpu_addr;
                        wdata_q      <= bus.cpu_wdata;
                        bus.cpu_busy <= 1'b1;
                        state        <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        if (bus.hit_count != 16'hFFFF)
                            bus.hit_count <= bus.hit_count + 16'd1;
                        if (we_q)
                            dirty[idx_q] <= 1'b1;
                        bus.cpu_done  <= 1'b1;
                        bus.cpu_rdata <= rd_byte;
                        state         <= RESP;
                    end else begin
                        if (bus.miss_count != 16'hFFFF)
                            bus.miss_count <= bus.miss_count + 16'd1;
                        if (dirty[idx_q]) begin
                            bus.mem_cmd   <= CMD_WRITE;
                            bus.mem_addr  <= {tag_arr[idx_q], idx_q, {CACHE_OFFSET_SIZE{1'b0}}};
                            bus.mem_wdata <= data_arr[idx_q];
                            state         <= WRITEBACK;
                        end else begin
                            bus.mem_cmd  <= CMD_READ;
                            bus.mem_addr <= {tag_q, idx_q, {CACHE_OFFSET_SIZE{1'b0}}};
                            state        <= FILL;
                        end
                    end
                end
                WRITEBACK: begin
                    if (bus.mem_resp) begin
                        dirty[idx_q] <= 1'b0;
                        bus.mem_cmd  <= CMD_NONE;
                        state        <= FILL;
                    end
                end
                FILL: begin
                    // Arriving from WRITEBACK the bus idles one cycle before the read goes out
                    if (bus.mem_cmd == CMD_NONE) begin
                        bus.mem_cmd  <= CMD_READ;
                        bus.mem_addr <= {tag_q, idx_q, {CACHE_OFFSET_SIZE{1'b0}}};
                    end else if (fill_done) begin
                        valid[idx_q]  <= 1'b1;
                        dirty[idx_q]  <= we_q;
                        bus.mem_cmd   <= CMD_NONE;
                        bus.cpu_done  <= 1'b1;
                        bus.cpu_rdata <= rd_byte;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    bus.cpu_done  <= 1'b0;
                    bus.cpu_rdata <= '0;
                    bus.cpu_busy  <= 1'b0;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cache_ctrl.sv
// Randomized self-checking bench for cache_ctrl with a line memory responder
// and an abstract cache/memory reference model.
module tb_cache_ctrl;
    logic clk = 1'b0;
    logic reset_n = 1'b0;

    cache_ctrl_if bus ();
    cache_ctrl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // memory responder controls and logs (logs are only appended by the responder)
    bit   mem_en = 1'b1;
    int   wb_delay = 0;
    int   fill_delay = 0;
    int   unstable = 0;
    int   inject_req = 0;
    int   inject_done = 0;
    logic [1:0]   cmd_log [$];
    logic [18:0]  addr_log [$];
    logic [127:0] wd_log [$];
    logic [1:0]   trace_q [$];
    logic [127:0] mem_sim [int];
    int cbase, tbase, ubase;

    // reference model state
    logic [127:0] mem_ref [int];
    bit           mv [32];
    bit           md [32];
    logic [9:0]   mt [32];
    logic [127:0] ml [32];
    int           m_hits, m_miss;

    function automatic logic [127:0] dflt_line(input int la);
        logic [127:0] l;
        for (int i = 0; i < 16; i++) l[8*i +: 8] = 8'(la * 16 + 'h30 + i);
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin mv[i] = 1'b0; md[i] = 1'b0; end
        m_hits = 0;
        m_miss = 0;
    endtask

    task automatic model_access(input bit we, input logic [18:0] a, input logic [7:0] wd,
                                output bit hit, output bit wb, output logic [18:0] wb_addr,
                                output logic [127:0] wb_line, output logic [18:0] fill_addr,
                                output logic [7:0] rd);
        int idx, off, la;
        logic [9:0] tag;
        idx = int'(a[8:4]);
        off = int'(a[3:0]);
        tag = a[18:9];
        la  = int'(a >> 4);
        hit = mv[idx] && (mt[idx] == tag);
        wb = 1'b0; wb_addr = '0; wb_line = '0; fill_addr = '0;
        if (hit) m_hits = (m_hits < 65535) ? m_hits + 1 : m_hits;
        else     m_miss = (m_miss < 65535) ? m_miss + 1 : m_miss;
        if (!hit) begin
            if (md[idx]) begin
                wb = 1'b1;
                wb_addr = {mt[idx], 5'(idx), 4'h0};
                wb_line = ml[idx];
                mem_ref[int'(wb_addr >> 4)] = ml[idx];
            end
            fill_addr = {tag, 5'(idx), 4'h0};
            ml[idx] = mem_ref.exists(la) ? mem_ref[la] : dflt_line(la);
            mt[idx] = tag;
            mv[idx] = 1'b1;
            md[idx] = 1'b0;
        end
        if (we) begin
            ml[idx][8*off +: 8] = wd;
            md[idx] = 1'b1;
        end
        rd = ml[idx][8*off +: 8];
    endtask

    // memory: answers each command after its configured delay, checking it stays stable meanwhile
    initial begin
        int cnt;
        int la;
        logic [1:0]   c0;
        logic [18:0]  a0;
        logic [127:0] w0;
        cnt = 0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            bus.mem_resp = 1'b0;
            trace_q.push_back(bus.mem_cmd);
            if (inject_done != inject_req) begin
                inject_done = inject_req;
                bus.mem_rdata = '1;
                bus.mem_resp = 1'b1;
            end else if (mem_en && reset_n && (bus.mem_cmd == 2'd2 || bus.mem_cmd == 2'd3)) begin
                if (cnt == 0) begin
                    c0 = bus.mem_cmd; a0 = bus.mem_addr; w0 = bus.mem_wdata;
                end else if (bus.mem_cmd !== c0 || bus.mem_addr !== a0 ||
                             (c0 == 2'd3 && bus.mem_wdata !== w0)) begin
                    unstable++;
                end
                if (cnt >= ((bus.mem_cmd == 2'd3) ? wb_delay : fill_delay)) begin
                    la = int'(bus.mem_addr >> 4);
                    cmd_log.push_back(bus.mem_cmd);
                    addr_log.push_back(bus.mem_addr);
                    wd_log.push_back(bus.mem_wdata);
                    if (bus.mem_cmd == 2'd3) mem_sim[la] = bus.mem_wdata;
                    else bus.mem_rdata = mem_sim.exists(la) ? mem_sim[la] : dflt_line(la);
                    bus.mem_resp = 1'b1;
                    cnt = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // lat counts sample points from the request cycle (0); -1 means no cpu_done within budget
    task automatic run_access(input bit we, input logic [18:0] a, input logic [7:0] wd,
                              input bit noise, output int lat, output logic [7:0] rd,
                              output bit leak);
        cbase = cmd_log.size();
        tbase = trace_q.size();
        ubase = unstable;
        leak = 1'b0;
        rd = 'x;
        lat = 0;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = wd;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        forever begin
            @(negedge clk);
            lat++;
            if (bus.cpu_done) begin rd = bus.cpu_rdata; break; end
            if (bus.cpu_rdata !== 8'h00) leak = 1'b1;
            if (lat > 400) begin lat = -1; break; end
            if (noise && bus.mem_cmd != 2'd0) begin
                bus.cpu_req = 1'b1;
                bus.cpu_we = 1'($urandom);
                bus.cpu_addr = 19'($urandom);
                @(posedge clk);
                #1 bus.cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++; if (bus.cpu_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.cpu_busy); end
        n_cmp++; if (bus.cpu_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", bus.cpu_done); end
        n_cmp++; if (bus.cpu_rdata !== 8'h00) begin n_err++; $display("FAIL reset_rdata: got %h want 00", bus.cpu_rdata); end
        n_cmp++; if (bus.mem_cmd !== 2'd0) begin n_err++; $display("FAIL reset_mem_cmd: got %0d want 0", bus.mem_cmd); end
        n_cmp++; if (bus.mem_addr !== 19'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", bus.mem_addr); end
        n_cmp++; if (bus.mem_wdata !== 128'h0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", bus.mem_wdata); end
        n_cmp++; if (bus.hit_count !== 16'h0 || bus.miss_count !== 16'h0) begin
            n_err++; $display("FAIL reset_counts: got %0d/%0d want 0/0", bus.hit_count, bus.miss_count); end
        model_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.cpu_busy !== 1'b0 || bus.mem_cmd !== 2'd0) begin
            n_err++; $display("FAIL idle_after_reset: busy %b cmd %0d want 0/0", bus.cpu_busy, bus.mem_cmd); end
    endtask

    task automatic test_cold_read();
        int lat; logic [7:0] rd, erd; bit leak, hit, wb;
        logic [18:0] wa, fa; logic [127:0] wl;
        model_access(1'b0, 19'h00013, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, 19'h00013, 8'h00, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() - cbase != 1 || cmd_log[cbase] !== 2'd2) begin
            n_err++; $display("FAIL cold_cmd: got %0d cmds want one READ", cmd_log.size() - cbase); end
        n_cmp++; if (addr_log.size() <= cbase || addr_log[cbase] !== 19'h00010) begin
            n_err++; $display("FAIL cold_addr: got %h want 00010", (addr_log.size() > cbase) ? addr_log[cbase] : 19'h7FFFF); end
        n_cmp++; if (rd !== 8'h43) begin n_err++; $display("FAIL cold_rdata: got %h want 43", rd); end
        n_cmp++; if (bus.miss_count !== 16'd1) begin n_err++; $display("FAIL cold_miss_count: got %0d want 1", bus.miss_count); end
        n_cmp++; if (leak !== 1'b0) begin n_err++; $display("FAIL cold_rdata_outside_resp: got %b want 0", leak); end
    endtask

    task automatic test_hit_read();
        int lat; logic [7:0] rd, erd; bit leak, hit, wb;
        logic [18:0] wa, fa; logic [127:0] wl;
        model_access(1'b0, 19'h0001F, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, 19'h0001F, 8'h00, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() != cbase) begin n_err++; $display("FAIL hit_no_cmd: got %0d cmds want 0", cmd_log.size() - cbase); end
        n_cmp++; if (lat != 2) begin n_err++; $display("FAIL hit_latency: got %0d want 2", lat); end
        n_cmp++; if (rd !== 8'h4F) begin n_err++; $display("FAIL hit_rdata: got %h want 4F", rd); end
        n_cmp++; if (bus.hit_count !== 16'd1) begin n_err++; $display("FAIL hit_count: got %0d want 1", bus.hit_count); end
    endtask

    task automatic test_writeback();
        int lat, i3; logic [7:0] rd, erd; bit leak, hit, wb;
        logic [18:0] wa, fa; logic [127:0] wl; logic [3:0] gap;
        model_access(1'b1, 19'h00012, 8'hAA, hit, wb, wa, wl, fa, erd);
        run_access(1'b1, 19'h00012, 8'hAA, 1'b0, lat, rd, leak);
        n_cmp++; if (lat != 2 || cmd_log.size() != cbase) begin
            n_err++; $display("FAIL write_hit: got lat %0d cmds %0d want 2/0", lat, cmd_log.size() - cbase); end
        model_access(1'b0, 19'h02012, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, 19'h02012, 8'h00, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() - cbase != 2) begin n_err++; $display("FAIL wb_cmd_count: got %0d want 2", cmd_log.size() - cbase); end
        else begin
            n_cmp++; if (cmd_log[cbase] !== 2'd3 || addr_log[cbase] !== 19'h00010) begin
                n_err++; $display("FAIL wb_first: got cmd %0d addr %h want 3 00010", cmd_log[cbase], addr_log[cbase]); end
            n_cmp++; if (wd_log[cbase][23:16] !== 8'hAA || wd_log[cbase] !== wl) begin
                n_err++; $display("FAIL wb_data: got %h want %h", wd_log[cbase], wl); end
            n_cmp++; if (cmd_log[cbase+1] !== 2'd2 || addr_log[cbase+1] !== 19'h02010) begin
                n_err++; $display("FAIL wb_fill: got cmd %0d addr %h want 2 02010", cmd_log[cbase+1], addr_log[cbase+1]); end
        end
        i3 = -1;
        for (int i = tbase; i < trace_q.size(); i++) if (trace_q[i] == 2'd3) i3 = i;
        gap = (i3 >= 0 && i3 + 2 < trace_q.size()) ? {trace_q[i3+1], trace_q[i3+2]} : 4'hF;
        n_cmp++; if (gap !== 4'b0010) begin n_err++; $display("FAIL wb_gap: got cmds %b after WRITE want 00,10", gap); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL wb_rdata: got %h want %h", rd, erd); end
    endtask

    task automatic test_write_miss();
        int lat; logic [7:0] rd, erd; bit leak, hit, wb;
        logic [18:0] wa, fa; logic [127:0] wl;
        model_access(1'b1, 19'h00400, 8'h55, hit, wb, wa, wl, fa, erd);
        run_access(1'b1, 19'h00400, 8'h55, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() - cbase != 1 || cmd_log[cbase] !== 2'd2 || addr_log[cbase] !== 19'h00400) begin
            n_err++; $display("FAIL wmiss_fill: got %0d cmds want one READ of 00400", cmd_log.size() - cbase); end
        model_access(1'b0, 19'h00400, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, 19'h00400, 8'h00, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() != cbase || lat != 2) begin
            n_err++; $display("FAIL wmiss_reread_hit: got cmds %0d lat %0d want 0/2", cmd_log.size() - cbase, lat); end
        n_cmp++; if (rd !== 8'h55) begin n_err++; $display("FAIL wmiss_rdata: got %h want 55", rd); end
    endtask

    task automatic test_fill_delay();
        int lat, n2; logic [7:0] rd, erd; bit leak, hit, wb;
        logic [18:0] wa, fa; logic [127:0] wl;
        fill_delay = 10;
        model_access(1'b0, 19'h0A0A5, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, 19'h0A0A5, 8'h00, 1'b1, lat, rd, leak);
        fill_delay = 0;
        n2 = 0;
        for (int i = tbase; i < trace_q.size(); i++) if (trace_q[i] == 2'd2) n2++;
        n_cmp++; if (n2 != 11) begin n_err++; $display("FAIL delay_hold_cycles: got %0d want 11", n2); end
        n_cmp++; if (unstable != ubase) begin n_err++; $display("FAIL delay_stable: got %0d changes want 0", unstable - ubase); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL delay_rdata: got %h want %h", rd, erd); end
        n_cmp++; if (bus.hit_count !== 16'(m_hits) || bus.miss_count !== 16'(m_miss)) begin
            n_err++; $display("FAIL delay_counts: got %0d/%0d want %0d/%0d", bus.hit_count, bus.miss_count, m_hits, m_miss); end
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.cpu_busy !== 1'b0) begin n_err++; $display("FAIL delay_no_queue: got busy %b want 0", bus.cpu_busy); end
    endtask

    task automatic test_reset_mid_fill();
        int lat, idx; logic [7:0] rd, erd; bit leak, hit, wb, seen;
        logic [18:0] a, wa, fa; logic [127:0] wl;
        idx = 31;
        for (int i = 31; i >= 0; i--) if (!md[i]) idx = i;
        a = {10'h3C5, 5'(idx), 4'h9};
        fill_delay = 1000;
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = a;
        @(posedge clk);
        #1 bus.cpu_req = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin @(negedge clk); seen = (bus.mem_cmd == 2'd2); end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL rst_fill_started: got %b want 1", seen); end
        #2 reset_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_cmd !== 2'd0 || bus.cpu_busy !== 1'b0) begin
            n_err++; $display("FAIL rst_async: got cmd %0d busy %b want 0/0", bus.mem_cmd, bus.cpu_busy); end
        model_reset();
        fill_delay = 0;
        @(negedge clk);
        reset_n = 1'b1;
        inject_req++;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.cpu_busy !== 1'b0 || bus.mem_cmd !== 2'd0 || bus.cpu_done !== 1'b0) begin
            n_err++; $display("FAIL rst_stale_resp: got busy %b cmd %0d done %b want 0/0/0", bus.cpu_busy, bus.mem_cmd, bus.cpu_done); end
        model_access(1'b0, a, 8'h00, hit, wb, wa, wl, fa, erd);
        run_access(1'b0, a, 8'h00, 1'b0, lat, rd, leak);
        n_cmp++; if (cmd_log.size() - cbase != 1 || addr_log[cbase] !== {a[18:4], 4'h0}) begin
            n_err++; $display("FAIL rst_remiss: got %0d cmds want one READ", cmd_log.size() - cbase); end
        n_cmp++; if (bus.miss_count !== 16'd1 || bus.hit_count !== 16'd0) begin
            n_err++; $display("FAIL rst_counts: got %0d/%0d want 0/1", bus.hit_count, bus.miss_count); end
        n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rst_rdata: got %h want %h", rd, erd); end
    endtask

    task automatic test_random();
        int lat, nc; logic [7:0] rd, erd, wd; bit leak, hit, wb, we;
        logic [18:0] a, wa, fa; logic [127:0] wl;
        for (int n = 0; n < 150; n++) begin
            we = 1'($urandom_range(0, 1));
            a = {10'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 4'($urandom_range(0, 15))};
            wd = 8'($urandom);
            wb_delay = $urandom_range(0, 3);
            fill_delay = $urandom_range(0, 3);
            model_access(we, a, wd, hit, wb, wa, wl, fa, erd);
            run_access(we, a, wd, 1'b0, lat, rd, leak);
            nc = cmd_log.size() - cbase;
            n_cmp++; if (lat < 0) begin n_err++; $display("FAIL rnd_timeout[%0d]: no cpu_done for %h", n, a); end
            n_cmp++; if (nc != (hit ? 0 : (wb ? 2 : 1))) begin
                n_err++; $display("FAIL rnd_cmd_count[%0d]: got %0d want %0d addr %h", n, nc, hit ? 0 : (wb ? 2 : 1), a); end
            else if (!hit) begin
                n_cmp++; if (cmd_log[cbase+nc-1] !== 2'd2 || addr_log[cbase+nc-1] !== fa) begin
                    n_err++; $display("FAIL rnd_fill[%0d]: got %0d@%h want 2@%h", n, cmd_log[cbase+nc-1], addr_log[cbase+nc-1], fa); end
                if (wb) begin
                    n_cmp++; if (cmd_log[cbase] !== 2'd3 || addr_log[cbase] !== wa || wd_log[cbase] !== wl) begin
                        n_err++; $display("FAIL rnd_wb[%0d]: got %0d@%h %h want 3@%h %h", n, cmd_log[cbase], addr_log[cbase], wd_log[cbase], wa, wl); end
                end
            end
            if (hit) begin
                n_cmp++; if (lat != 2) begin n_err++; $display("FAIL rnd_hit_latency[%0d]: got %0d want 2", n, lat); end
            end
            if (!we) begin
                n_cmp++; if (rd !== erd) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h addr %h", n, rd, erd, a); end
            end
            n_cmp++; if (leak !== 1'b0) begin n_err++; $display("FAIL rnd_rdata_outside_resp[%0d]: got %b want 0", n, leak); end
        end
        wb_delay = 0;
        fill_delay = 0;
        n_cmp++; if (bus.hit_count !== 16'(m_hits) || bus.miss_count !== 16'(m_miss)) begin
            n_err++; $display("FAIL rnd_counts: got %0d/%0d want %0d/%0d", bus.hit_count, bus.miss_count, m_hits, m_miss); end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cpu_req = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        test_reset();
        test_cold_read();
        test_hit_read();
        test_writeback();
        test_write_miss();
        test_fill_delay();
        test_reset_mid_fill();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
